// File: rtl/range_finder_pio_pkg.sv
// range_finder_pio_pkg: register offsets and edge-type selectors shared by the range-finder PIO
package range_finder_pio_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/range_finder_pio_sync.sv
// range_finder_pio_sync: optional 2-flop input synchronizer (RANGE_FINDER_PIO_IN_SYNC_EN), previous-sample register and edge detect
module range_finder_pio_sync
  import range_finder_pio_pkg::*;
#(
  parameter int          DATA_W    = 9,
  parameter int          EDGE_TYPE = 0,
  parameter logic [31:0] RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] edge_det
);
  localparam logic [DATA_W-1:0] RV = RESET_VAL[DATA_W-1:0];
  logic [DATA_W-1:0] p;
`ifdef RANGE_FINDER_PIO_IN_SYNC_EN
  logic [DATA_W-1:0] s1, s2;
  // two-stage synchronizer for inputs that are asynchronous to clk
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= RV;
      s2 <= RV;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  assign data = s2;
`else
  assign data = in_port;
`endif
  // previous sample of the (synchronized) input
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) p <= RV;
    else p <= data;
  // per-bit edge selection
  always_comb
    edge_det = EDGE_TYPE == EDGE_FALL ? ~data & p :
               EDGE_TYPE == EDGE_ANY  ? data ^ p  : data & ~p;
endmodule

// File: rtl/range_finder_pio_in_edge.sv
// range_finder_pio_in_edge: Avalon-MM input PIO with edge capture and masked level irq; sync stage enabled by RANGE_FINDER_PIO_IN_SYNC_EN
module range_finder_pio_in_edge
  import range_finder_pio_pkg::*;
#(
  parameter int          DATA_W    = 9,
  parameter int          EDGE_TYPE = 0,
  parameter logic [31:0] RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [DATA_W-1:0] in_port,
  output logic [31:0]       readdata,
  output logic              irq
);
  logic [DATA_W-1:0] data, edge_det, mask, cap, clr, rd;
  logic wr;
  range_finder_pio_sync #(.DATA_W(DATA_W), .EDGE_TYPE(EDGE_TYPE), .RESET_VAL(RESET_VAL)) u_sync (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .data(data), .edge_det(edge_det)
  );
  // bus decode: write strobe, write-1-to-clear vector and read mux
  always_comb begin
    wr  = chipselect & ~write_n;
    clr = (wr && address == ADDR_EDGECAP) ? writedata[DATA_W-1:0] : '0;
    rd  = address == ADDR_DATA    ? data :
          address == ADDR_IRQMASK ? mask :
          address == ADDR_EDGECAP ? cap  : '0;
  end
  // registers: mask write, edge capture (new edge beats a same-cycle clear), registered read data
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mask     <= '0;
      cap      <= '0;
      readdata <= '0;
    end else begin
      if (wr && address == ADDR_IRQMASK) mask <= writedata[DATA_W-1:0];
      cap      <= (cap & ~clr) | edge_det;
      readdata <= 32'(rd);
    end
  assign irq = |(cap & mask);
endmodule

// File: tb/tb_range_finder_pio_in_edge.sv
// tb_range_finder_pio_in_edge: randomized + directed check of rise/fall/any DUTs against a cycle-level reference model
module tb_range_finder_pio_in_edge;
  localparam int W = 9;
`ifdef RANGE_FINDER_PIO_IN_SYNC_EN
  localparam int N = 2;
`else
  localparam int N = 0;
`endif
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0;
  logic [W-1:0] in_port = 0;
  logic [31:0] rdata [3];
  logic irq_o [3];
  int total = 0, bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    range_finder_pio_in_edge #(.DATA_W(W), .EDGE_TYPE(g), .RESET_VAL(0)) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[g]), .irq(irq_o[g])
    );
  end

  always #5 clk = ~clk;

  logic [W-1:0] m_mask, m_p;
  logic [W-1:0] m_cap [3];
  logic [W-1:0] m_rd [3];
  logic [W-1:0] hist [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] edge_of(int t, logic [W-1:0] s, logic [W-1:0] p);
    logic [W-1:0] r = '0;
    for (int b = 0; b < W; b++)
      r[b] = t == 0 ? (s[b] == 1 && p[b] == 0) :
             t == 1 ? (s[b] == 0 && p[b] == 1) : (s[b] != p[b]);
    return r;
  endfunction

  task automatic m_reset();
    m_mask = 0;
    m_p = 0;
    for (int t = 0; t < 3; t++) begin
      m_cap[t] = 0;
      m_rd[t] = 0;
    end
    hist = {};
    for (int i = 0; i < N; i++) hist.push_back('0);
  endtask

  task automatic tick();
    logic [W-1:0] s, clr;
    logic wr;
    @(posedge clk);
    s = in_port;
    if (N > 0) begin
      s = hist.pop_front();
      hist.push_back(in_port);
    end
    wr = chipselect && !write_n;
    clr = (wr && address == 3) ? writedata[W-1:0] : '0;
    for (int t = 0; t < 3; t++) begin
      m_rd[t] = address == 0 ? s : address == 2 ? m_mask : address == 3 ? m_cap[t] : '0;
      m_cap[t] = (m_cap[t] & ~clr) | edge_of(t, s, m_p);
    end
    if (wr && address == 2) m_mask = writedata[W-1:0];
    m_p = s;
    #1;
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("rd%0d", t), rdata[t], {23'b0, m_rd[t]});
      chk($sformatf("irq%0d", t), {31'b0, irq_o[t]}, {31'b0, |(m_cap[t] & m_mask)});
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1;
    write_n = 0;
    tick();
    chipselect = 0;
    write_n = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int t = 0; t < 3; t++) begin
      chk({tag, "_rd"}, rdata[t], 0);
      chk({tag, "_irq"}, {31'b0, irq_o[t]}, 0);
    end
  endtask

  initial begin
    m_reset();
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      chk_all_zero("idle");
    end
    in_port = 9'h0A5;
    address = 0;
    repeat (5) tick();
    chk("data_a5", rdata[0], 32'h0000_00A5);
    in_port = 0;
    repeat (N + 2) tick();
    bus_write(3, 32'h1FF);
    bus_write(2, 32'h001);
    in_port[0] = 1;
    repeat (N + 1) tick();
    chk("rise0_irq", {31'b0, irq_o[0]}, 1);
    address = 3;
    tick();
    chk("rise0_cap", rdata[0], 1);
    bus_write(3, 32'h001);
    chk("clr0_irq", {31'b0, irq_o[0]}, 0);
    bus_write(2, 32'h000);
    in_port[3] = 1;
    repeat (N + 1) tick();
    address = 3;
    tick();
    chk("bit3_cap", {31'b0, rdata[0][3]}, 1);
    chk("bit3_noirq", {31'b0, irq_o[0]}, 0);
    bus_write(2, 32'h008);
    chk("bit3_irq", {31'b0, irq_o[0]}, 1);
    bus_write(3, 32'h1FF);
    in_port[2] = 1;
    repeat (N) tick();
    bus_write(3, 32'h004);
    address = 3;
    tick();
    chk("setwins_cap", {31'b0, rdata[0][2]}, 1);
    in_port[8] = ~in_port[8];
    repeat (N + 2) tick();
    in_port[8] = ~in_port[8];
    repeat (N + 1) tick();
    chk("any8_cap", {31'b0, m_cap[2][8]}, 1);
    #2 reset_n = 0;
    m_reset();
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    reset_n = 1;
    bus_write(1, 32'hFFFF_FFFF);
    address = 1;
    tick();
    chk("rsvd_rd", rdata[0], 0);
    repeat (3000) begin
      address = 2'($urandom_range(0, 3));
      chipselect = $urandom_range(0, 3) == 0;
      write_n = $urandom_range(0, 1) == 0;
      writedata = $urandom;
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/range_finder_pio_in_edge.md
RANGE_FINDER_PIO_IN_EDGE -- requirements
Module: range_finder_pio_in_edge

Interface
REQ-001 Parameter DATA_W, default 9: width of in_port and of every per-bit register (1..32).
REQ-002 Parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge.
REQ-003 Parameter RESET_VAL, default 0: reset value of the sync chain and the previous-sample register.
REQ-004 Port clk, input, 1: the single clock; all logic is posedge clk. Reset is asynchronous, active-low.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port address, input, 2: Avalon-MM slave word address.
REQ-007 Port chipselect, input, 1: slave select.
REQ-008 Port write_n, input, 1: active-low write strobe, qualified by chipselect.
REQ-009 Port writedata, input, 32: write data.
REQ-010 Port in_port, input, DATA_W: asynchronous external inputs (range-finder distance/status bits).
REQ-011 Port readdata, output, 32: registered read data.
REQ-012 Port irq, output, 1: level interrupt, active-high.

Function
REQ-013 Register map: 0 = DATA (RO, sampled input), 1 = reserved (reads 0, writes ignored), 2 = IRQMASK (RW), 3 = EDGECAPTURE (RO, write-1-to-clear per bit).
REQ-014 readdata is updated every clock from the address-selected register, zero-extended to 32 bits; read latency is exactly 1 cycle, with no read strobe.
REQ-015 Writes take effect when chipselect=1 and write_n=0; only writedata[DATA_W-1:0] is used and upper bits are ignored.
REQ-016 DATA is the sampled input s (see REQ-024/025); the previous-sample register p captures s every cycle.
REQ-017 Edge detect per bit: rising = s&~p, falling = ~s&p, any = s^p, selected by EDGE_TYPE.
REQ-018 EDGECAPTURE bit sets on a detected edge and holds until cleared by writing 1 to that bit at address 3.
REQ-019 When a clear and a new edge hit the same bit in the same cycle, the set wins and the bit stays 1.
REQ-020 irq = |(EDGECAPTURE & IRQMASK), driven combinationally from registers with no added latency; it stays asserted until every unmasked captured bit is cleared.
REQ-021 A write to IRQMASK takes effect on irq in the cycle after the write edge.
REQ-022 An edge on in_port appears in EDGECAPTURE N+1 cycles after the sampling clock, where N is the number of sync stages (N = 2 or 0).

Reset
REQ-023 On reset_n=0, asynchronously: readdata=0, IRQMASK=0, EDGECAPTURE=0, sync stages and p = RESET_VAL, and irq=0. Reset asserted mid-operation discards any pending edges, and no edge is detected on the first cycle after release unless the input differs from RESET_VAL.

Configuration
REQ-024 With macro RANGE_FINDER_PIO_IN_SYNC_EN defined, in_port passes through a 2-flop synchronizer before s, and the DATA latency is 2 cycles plus the read cycle.
REQ-025 Without the macro, s = in_port directly (inputs are already synchronous to clk) and p is the only edge register.

Structure
REQ-026 Package range_finder_pio_pkg holds the register offset constants (ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP) and the EDGE_RISE/EDGE_FALL/EDGE_ANY constants.
REQ-027 Sub-module range_finder_pio_sync, parametrised by DATA_W, EDGE_TYPE and RESET_VAL, contains the optional synchronizer, p, and the edge-detect vector output; the top level holds the registers and the bus decode.

Verification
REQ-028 Reset release, no activity: readdata=0 and irq=0 at all four addresses; after in_port=9'h0A5 for 5 cycles, a read of address 0 returns 32'h000000A5.
REQ-029 EDGE_TYPE=0, IRQMASK=9'h001: a rising edge on in_port[0] gives EDGECAPTURE=1 and irq=1 at N+1 cycles; writing 1 to address 3 clears it and drops irq the next cycle.
REQ-030 Edge on bit 3 with IRQMASK=0: EDGECAPTURE[3]=1 and irq=0; writing IRQMASK=9'h008 raises irq one cycle later.
REQ-031 Write-1-to-clear of bit 2 in the same cycle as a new rising edge on bit 2: EDGECAPTURE[2] remains 1.
REQ-032 EDGE_TYPE=2, a toggle on bit 8, then reset_n pulsed low mid-run: all registers return to 0 asynchronously, and a write to address 1 followed by a read returns 0.
